// File: rtl/regfile_pkg.sv
// Register-file-wide constants and the writeback request payload, shared with
// the register file and the execute stages.
package regfile_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter with a 1-bit pointer and one-hot grant.
// req[0] is the ALU, req[1] is the load unit; the pointer starts favouring req[1].
module wb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;

  // The pointer only moves after a contested grant so a lone requester never loses its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b1;
    end else if (&req) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register file write-port controller: arbitrates ALU/load writebacks into a
// single registered output stage and tracks pending writes per register.
// Optional result forwarding from the output stage is enabled by WB_FORWARD_EN.
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueDest,
  output logic                  issueReady,
  input  logic [ADDR_WIDTH-1:0] srcReg1,
  input  logic [ADDR_WIDTH-1:0] srcReg2,
  output logic                  srcBusy1,
  output logic                  srcBusy2,
`ifdef WB_FORWARD_EN
  output logic                  fwdValid1,
  output logic                  fwdValid2,
  output logic [DATA_WIDTH-1:0] fwdData1,
  output logic [DATA_WIDTH-1:0] fwdData2,
`endif
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluDest,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [ADDR_WIDTH-1:0] memDest,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  wbErr
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [1:0]          grant;
  wb_req_t             alu_req;
  wb_req_t             mem_req;
  wb_req_t             sel;
  logic                issue_accept;
  logic                sel_busy;
  logic                fwd_hit1;
  logic                fwd_hit2;

  assign alu_req = '{valid: aluValid, dest: aluDest, data: aluData};
  assign mem_req = '{valid: memValid, dest: memDest, data: memData};

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (reset_n),
    .req   ({mem_req.valid, alu_req.valid}),
    .grant (grant)
  );

  assign aluReady = grant[0];
  assign memReady = grant[1];

  always_comb begin
    sel       = grant[1] ? mem_req : alu_req;
    sel.valid = |grant;
  end

  // A register being committed this cycle is free for a new issue on the same edge.
  assign issueReady   = (issueDest == ZERO_REG) || !busy[issueDest] ||
                        (regWrite && (writeReg == issueDest));
  assign issue_accept = issueValid && issueReady;

  // Busy as seen after this edge's commit, so back-to-back writes to one register flag the second.
  assign sel_busy = busy[sel.dest] && !(regWrite && (writeReg == sel.dest));

  always_comb begin
    busy_next = busy;
    if (regWrite) begin
      busy_next[writeReg] = 1'b0;
    end
    if (issue_accept && (issueDest != ZERO_REG)) begin
      busy_next[issueDest] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= '0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      wbErr     <= 1'b0;
    end else begin
      busy     <= busy_next;
      regWrite <= sel.valid && (sel.dest != ZERO_REG);
      if (sel.valid) begin
        writeReg  <= sel.dest;
        writeData <= sel.data;
      end
      if (sel.valid && (sel.dest != ZERO_REG) && !sel_busy) begin
        wbErr <= 1'b1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_hit1  = regWrite && (writeReg == srcReg1) && (srcReg1 != ZERO_REG);
  assign fwd_hit2  = regWrite && (writeReg == srcReg2) && (srcReg2 != ZERO_REG);
  assign fwdValid1 = fwd_hit1;
  assign fwdValid2 = fwd_hit2;
  assign fwdData1  = writeData;
  assign fwdData2  = writeData;
`else
  assign fwd_hit1 = 1'b0;
  assign fwd_hit2 = 1'b0;
`endif

  assign srcBusy1 = busy[srcReg1] && !fwd_hit1;
  assign srcBusy2 = busy[srcReg2] && !fwd_hit2;

endmodule
